semaphore_lock_arbiter: RTL
===========================

Name: semaphore_lock_arbiter

Overview:
Clocked successor to the combinational semaphore write-enable gate of the multicore PLC unit. It tracks ownership of NumberOfSemaphores hardware semaphores shared by NumberOfCores cores and grants each semaphore to one core at a time, using per-semaphore round-robin arbitration. Each core's write-enable to a semaphore passes only while that core holds the grant. An optional timeout force-releases a semaphore held too long. The block sits between the per-core address/WE decoders and the semaphore storage.

Parameters:
NumberOfSemaphores, 4, number of independent semaphores (S), >=1
NumberOfCores, 2, number of requesting cores (C), >=1
TimeoutCycles, 0, maximum hold time in cycles; 0 disables the timeout
OwnerW, derived = max(1, clog2(C)), owner-index width (localparam)

Ports:
SEMAPHORECTRL_CLK  in  1  single clock, rising edge
SEMAPHORECTRL_nRST  in  1  reset, asynchronous assert, active-low
SEMAPHORECTRL_lockReq  in  S*C  lock request; bit s*C+c = core c requests semaphore s (level)
SEMAPHORECTRL_release  in  S*C  release strobe, same indexing
SEMAPHORECTRL_WE_buffer  in  S*C  decoded write-enable from the cores, same indexing
SEMAPHORECTRL_grant  out  S*C  registered; at most one bit set per semaphore slice
SEMAPHORECTRL_locked  out  S  registered; semaphore s is owned
SEMAPHORECTRL_owner  out  S*OwnerW  registered owner index; slice s at [s*OwnerW +: OwnerW]
SEMAPHORECTRL_timeout  out  S  one-cycle pulse when semaphore s is force-released
SEMAPHORECTRL_WE_toSemaphore  out  S*C  combinational = WE_buffer & grant; no tri-state

Behaviour:
- Reset (nRST low, asynchronous): grant=0, locked=0, owner=0, timeout=0. Every round-robin pointer rrPtr=0 and every hold counter=0. Outputs hold these values until the first rising edge after deassertion.
- Per semaphore, two states: FREE and LOCKED. Semaphores are fully independent.
- FREE: if any lockReq bit in the slice is set, winner = first requesting core searching from rrPtr upward, wrapping modulo C. At the next edge: LOCKED, grant[winner]=1, owner=winner, rrPtr=(winner+1) mod C, counter=0. Latency: request in cycle N gives grant visible in cycle N+1.
- LOCKED, release by the owner: owner is excluded from arbitration this cycle.
  - If another core requests, hand off directly to its round-robin winner at the same edge. No FREE cycle occurs and the grant stays one-hot throughout.
  - Otherwise go to FREE: grant=0, locked=0, owner keeps its last value.
- Release from a non-owner, or release in FREE: ignored.
- Owner's lockReq held or dropped while LOCKED: no effect; only an explicit release or a timeout frees the semaphore.
- Simultaneous release and request from the same core: the release wins. That core is excluded and can re-win only in a later cycle.
- Timeout (TimeoutCycles>0): the counter increments each LOCKED cycle and saturates.
  - When counter==TimeoutCycles-1 and there is no owner release that cycle, a forced release occurs with the same handoff rules. SEMAPHORECTRL_timeout[s]=1 for exactly the following cycle.
  - If release and timeout coincide: normal release, no pulse.
  - After a handoff the counter restarts at 0.
- TimeoutCycles=0: counter logic removed, timeout tied to 0.
- C=1: rrPtr is constant 0 and owner is always 0.
- WE gating: WE_toSemaphore[i]=WE_buffer[i] & grant[i], combinational, no registering. A WE in the grant cycle passes; a WE after release is blocked.
- Reset asserted mid-hold: all ownership is lost immediately and asynchronously. Cores must re-request.

Decomposition:
- Package semaphore_pkg: state enum {SEM_FREE, SEM_LOCKED}, owner-width function, round-robin search function (request vector, pointer, exclude mask -> winner index + valid).
- Sub-module semaphore_slot: one semaphore's state, rrPtr, counter and grant register. It is instantiated S times in a generate loop.
- Top level: slicing, owner packing and WE AND gating.

Test Plan (S=4, C=4, TimeoutCycles=8 unless noted):
1. Reset release, core 2 sets lockReq[s0] at cycle 3 -> grant[2]=1, locked[0]=1, owner[0]=2 in cycle 4; WE_buffer[2] passes and WE_buffer[1] is blocked.
2. Cores 0,1,3 request s1 with rrPtr=0 -> core 0 wins. On core 0's release, handoff to 1, then 3, then 0. Grant stays one-hot with no gap cycles.
3. Non-owner release on s2 held by core 1 -> no change. Owner drops lockReq without releasing -> still LOCKED.
4. Core 3 holds s3 for 8 cycles with no release -> timeout[3]=1 for one cycle and locked[3]=0; with core 0 also requesting -> immediate handoff to core 0 plus pulse. Release coinciding with the timeout cycle -> no pulse.
5. nRST asserted mid-hold, between clock edges -> grant, locked and timeout go 0 immediately. After deassertion, a new request is granted with rrPtr=0.
6. All 16 request bits set simultaneously -> each semaphore granted independently to core 0 in one cycle. A WE_buffer all-ones vector then yields WE_toSemaphore = 0x1111.

Source files
------------

// File: rtl/semaphore_pkg.sv
// Purpose: shared types and helpers for the semaphore lock arbiter (state enum, owner width, round-robin search).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a; there is no flow control, requests are level-held until granted.
package semaphore_pkg;

  typedef enum logic {
    SEM_FREE   = 1'b0,
    SEM_LOCKED = 1'b1
  } sem_state_e;

  // The search function works on fixed-width vectors so it can live in the
  // package; slots zero-extend their per-core vectors up to this width.
  localparam int unsigned MAX_CORES = 32;
  localparam int unsigned RR_IDX_W  = 5;

  typedef struct packed {
    logic                vld;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned owner_width(input int unsigned cores);
    return (cores <= 1) ? 1 : $clog2(cores);
  endfunction

  // First requester at or after ptr, wrapping modulo n, skipping excluded cores.
  // ptr < n always holds, so a single conditional subtract implements the wrap.
  function automatic rr_pick_t rr_search(
    input logic [MAX_CORES-1:0] req,
    input logic [MAX_CORES-1:0] excl,
    input logic [RR_IDX_W-1:0]  ptr,
    input int unsigned          n
  );
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned i = 0; i < MAX_CORES; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= n) cand = cand - n;
      if ((i < n) && !pick.vld && req[cand[RR_IDX_W-1:0]] && !excl[cand[RR_IDX_W-1:0]]) begin
        pick.vld = 1'b1;
        pick.idx = cand[RR_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/semaphore_slot.sv
// Purpose: one semaphore's FREE/LOCKED state, round-robin pointer, hold counter and grant register.
// Latency: request in cycle N -> grant in cycle N+1; release/timeout hand off at the same edge.
// Backpressure: none; losing requesters simply keep their level request asserted.
// Ports: clk_i/rst_ni clock and async active-low reset; lock_req_i/release_i per-core
//        request level and release strobe; grant_o one-hot grant; locked_o owned flag;
//        owner_o last owner index; timeout_o one-cycle forced-release pulse.
module semaphore_slot
  import semaphore_pkg::*;
#(
  parameter int unsigned NumCores      = 2,
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned OwnerW        = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumCores-1:0] lock_req_i,
  input  logic [NumCores-1:0] release_i,
  output logic [NumCores-1:0] grant_o,
  output logic                locked_o,
  output logic [OwnerW-1:0]   owner_o,
  output logic                timeout_o
);

  sem_state_e          state_q;
  logic [NumCores-1:0] grant_q;
  logic [OwnerW-1:0]   owner_q;
  logic [OwnerW-1:0]   rr_ptr_q;
  logic                timeout_q;

  logic                owner_rel;
  logic                tmo_fire;
  logic                rearb;
  rr_pick_t            pick;
  logic [OwnerW-1:0]   win_idx;
  logic [OwnerW-1:0]   win_next_ptr;
  logic [RR_IDX_W:0]   next_ptr_wide;
  logic [NumCores-1:0] win_onehot;

  // grant_q is the owner one-hot while LOCKED and zero while FREE, so it
  // doubles as the release filter and as the arbitration exclude mask.
  assign owner_rel = (state_q == SEM_LOCKED) && (|(release_i & grant_q));
  assign rearb     = (state_q == SEM_FREE) || owner_rel || tmo_fire;
  assign pick      = rr_search(MAX_CORES'(lock_req_i), MAX_CORES'(grant_q),
                               RR_IDX_W'(rr_ptr_q), NumCores);

  assign win_idx       = pick.idx[OwnerW-1:0];
  assign next_ptr_wide = {1'b0, pick.idx} + (RR_IDX_W+1)'(1);
  assign win_next_ptr  = (next_ptr_wide == (RR_IDX_W+1)'(NumCores)) ? '0
                                                                     : next_ptr_wide[OwnerW-1:0];

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  if (TimeoutCycles > 0) begin : g_tmo
    // Counter only needs to reach TimeoutCycles-1; it is the firing point.
    localparam int unsigned CntW = (TimeoutCycles <= 1) ? 1 : $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    logic [CntW-1:0] cnt_q;

    assign tmo_fire = (state_q == SEM_LOCKED) && (cnt_q == CntLast) && !owner_rel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (rearb) begin
        cnt_q <= '0;
      end else if (cnt_q != CntLast) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end else begin : g_no_tmo
    assign tmo_fire = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SEM_FREE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // A release that coincides with the timeout suppresses tmo_fire, so no pulse.
      timeout_q <= tmo_fire;
      if (rearb) begin
        if (pick.vld) begin
          state_q  <= SEM_LOCKED;
          grant_q  <= win_onehot;
          owner_q  <= win_idx;
          rr_ptr_q <= win_next_ptr;
        end else begin
          // owner_q deliberately keeps the last holder.
          state_q <= SEM_FREE;
          grant_q <= '0;
        end
      end
    end
  end

  assign grant_o   = grant_q;
  assign locked_o  = (state_q == SEM_LOCKED);
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/semaphore_lock_arbiter.sv
// Purpose: per-semaphore round-robin lock arbiter gating core write-enables to semaphore storage.
// Latency: grant one cycle after request; WE_toSemaphore is combinational from WE_buffer and grant.
// Backpressure: none; ungranted cores hold lockReq, their write-enables are dropped while not owning.
// Ports: SEMAPHORECTRL_CLK/nRST clock and async active-low reset; lockReq/release/WE_buffer
//        per (semaphore,core) bit s*C+c; grant/locked/owner/timeout registered status;
//        WE_toSemaphore gated write-enable to storage.
module semaphore_lock_arbiter
  import semaphore_pkg::*;
#(
  parameter  int unsigned NumberOfSemaphores = 4,
  parameter  int unsigned NumberOfCores      = 2,
  parameter  int unsigned TimeoutCycles      = 0,
  localparam int unsigned OwnerW             = owner_width(NumberOfCores)
) (
  input  logic                                        SEMAPHORECTRL_CLK,
  input  logic                                        SEMAPHORECTRL_nRST,
  input  logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHORECTRL_lockReq,
  input  logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHORECTRL_release,
  input  logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHORECTRL_WE_buffer,
  output logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHORECTRL_grant,
  output logic [NumberOfSemaphores-1:0]               SEMAPHORECTRL_locked,
  output logic [NumberOfSemaphores*OwnerW-1:0]        SEMAPHORECTRL_owner,
  output logic [NumberOfSemaphores-1:0]               SEMAPHORECTRL_timeout,
  output logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHORECTRL_WE_toSemaphore
);

  localparam int unsigned C = NumberOfCores;

  for (genvar s = 0; s < NumberOfSemaphores; s++) begin : g_slot
    semaphore_slot #(
      .NumCores      (C),
      .TimeoutCycles (TimeoutCycles),
      .OwnerW        (OwnerW)
    ) u_slot (
      .clk_i      (SEMAPHORECTRL_CLK),
      .rst_ni     (SEMAPHORECTRL_nRST),
      .lock_req_i (SEMAPHORECTRL_lockReq[s*C +: C]),
      .release_i  (SEMAPHORECTRL_release[s*C +: C]),
      .grant_o    (SEMAPHORECTRL_grant[s*C +: C]),
      .locked_o   (SEMAPHORECTRL_locked[s]),
      .owner_o    (SEMAPHORECTRL_owner[s*OwnerW +: OwnerW]),
      .timeout_o  (SEMAPHORECTRL_timeout[s])
    );
  end

  // Pure AND: a WE in the grant cycle passes, a WE after release is dropped.
  assign SEMAPHORECTRL_WE_toSemaphore = SEMAPHORECTRL_WE_buffer & SEMAPHORECTRL_grant;

endmodule
